// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encodings,
// the x0 register address and the legal load-use bubble range.
package hazard_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_MC_WAIT  = 2'd2;

   localparam int unsigned REG_ZERO = 0;

   localparam int LU_BUBBLES_MIN = 1;
   localparam int LU_BUBBLES_MAX = 3;

   // Out-of-range bubble counts are pulled back into the supported window.
   function automatic int clamp_lu_bubbles(input int req);
      if (req < LU_BUBBLES_MIN) return LU_BUBBLES_MIN;
      if (req > LU_BUBBLES_MAX) return LU_BUBBLES_MAX;
      return req;
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: increments while inc is high and holds at
// all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EX stalls and
// branch flushes, driving PC / IF/ID / ID/EX enables and flushes.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_RUN      | normal flow; hazards and redirects evaluated each cycle
// ST_LU_STALL | extra load-use bubbles still to insert (bub_q remaining)
// ST_MC_WAIT  | multi-cycle EX op in flight, pipeline frozen until done
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int LU_BUBBLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_ex_mem_read,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic [REG_AW-1:0] if_id_rs1,
   input  logic [REG_AW-1:0] if_id_rs2,
   input  logic              if_id_use_rs1,
   input  logic              if_id_use_rs2,
   input  logic              ex_branch_taken,
   input  logic              mc_start,
   input  logic              mc_done,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_write,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              stall_active,
   output logic [CNT_W-1:0]  stall_count
);

   localparam int LU_EFF = clamp_lu_bubbles(LU_BUBBLES);

   logic [1:0] state_q, state_d;
   logic [1:0] bub_q, bub_d;
   logic       lu_haz;
   logic       pc_write_c, if_id_write_c, id_ex_write_c;
   logic       if_id_flush_c, id_ex_flush_c, stall_c;

   assign lu_haz = id_ex_mem_read
                   && (id_ex_rd != REG_AW'(REG_ZERO))
                   && ((if_id_use_rs1 && (id_ex_rd == if_id_rs1))
                    || (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

   always_comb begin
      state_d       = state_q;
      bub_d         = bub_q;
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      id_ex_write_c = 1'b1;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      stall_c       = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (ex_branch_taken) begin
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
            end else if (mc_start && !mc_done) begin
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               id_ex_write_c = 1'b0;
               stall_c       = 1'b1;
               state_d       = ST_MC_WAIT;
            end else if (mc_start) begin
               // op finished in its issue cycle: nothing to hold
               state_d = ST_RUN;
            end else if (lu_haz) begin
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               id_ex_flush_c = 1'b1;
               stall_c       = 1'b1;
               if (LU_EFF > 1) begin
                  bub_d   = 2'(LU_EFF - 1);
                  state_d = ST_LU_STALL;
               end
            end
         end
         ST_LU_STALL: begin
            if (ex_branch_taken) begin
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               bub_d         = 2'd0;
               state_d       = ST_RUN;
            end else begin
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               id_ex_flush_c = 1'b1;
               stall_c       = 1'b1;
               bub_d         = bub_q - 2'd1;
               if (bub_q == 2'd1) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_MC_WAIT: begin
            if (mc_done) begin
               state_d = ST_RUN;
            end else begin
               pc_write_c    = 1'b0;
               if_id_write_c = 1'b0;
               id_ex_write_c = 1'b0;
               stall_c       = 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
            bub_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         bub_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
      end
   end

   // Outputs fall back to pass-through defaults while reset is held.
   assign pc_write     = rst_n ? pc_write_c    : 1'b1;
   assign if_id_write  = rst_n ? if_id_write_c : 1'b1;
   assign id_ex_write  = rst_n ? id_ex_write_c : 1'b1;
   assign if_id_flush  = rst_n ? if_id_flush_c : 1'b0;
   assign id_ex_flush  = rst_n ? id_ex_flush_c : 1'b0;
   assign stall_active = rst_n ? stall_c       : 1'b0;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_active),
      .count (stall_count)
   );

endmodule
